// File: rtl/char_string_drawer_pkg.sv
// Shared constants, FSM state encoding and character codes for the string drawer.
package char_string_drawer_pkg;

  localparam int unsigned CELL_W   = 10;
  localparam int unsigned CELL_H   = 10;
  localparam int unsigned ADVANCE  = 12;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned MAX_LEN  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SCAN,
    S_FLUSH,
    S_DONE
  } state_e;

  // Character codes: digits 0..9, letters A..Z from 10, then space.
  localparam logic [5:0] CHAR_0     = 6'd0;
  localparam logic [5:0] CHAR_1     = 6'd1;
  localparam logic [5:0] CHAR_2     = 6'd2;
  localparam logic [5:0] CHAR_3     = 6'd3;
  localparam logic [5:0] CHAR_4     = 6'd4;
  localparam logic [5:0] CHAR_5     = 6'd5;
  localparam logic [5:0] CHAR_6     = 6'd6;
  localparam logic [5:0] CHAR_7     = 6'd7;
  localparam logic [5:0] CHAR_8     = 6'd8;
  localparam logic [5:0] CHAR_9     = 6'd9;
  localparam logic [5:0] CHAR_A     = 6'd10;
  localparam logic [5:0] CHAR_E     = 6'd14;
  localparam logic [5:0] CHAR_G     = 6'd16;
  localparam logic [5:0] CHAR_M     = 6'd22;
  localparam logic [5:0] CHAR_O     = 6'd24;
  localparam logic [5:0] CHAR_R     = 6'd27;
  localparam logic [5:0] CHAR_S     = 6'd28;
  localparam logic [5:0] CHAR_V     = 6'd31;
  localparam logic [5:0] CHAR_Y     = 6'd34;
  localparam logic [5:0] CHAR_SPACE = 6'd36;

  // Requests longer than the string buffer are clamped to its size.
  function automatic logic [4:0] sat_len(input logic [4:0] len);
    return (len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/char_string_drawer_if.sv
// Bundle of the drawer's request, string-buffer, glyph-LUT and plot signals.
interface char_string_drawer_if;

  logic       start;
  logic [7:0] base_x;
  logic [7:0] base_y;
  logic [4:0] str_len;
  logic       clear_bg;
  logic [5:0] bg_colour;

  logic [3:0] char_addr;
  logic [5:0] char_code;

  logic [5:0] glyph_code;
  logic [7:0] glyph_x;
  logic [7:0] glyph_y;
  logic [5:0] glyph_colour;
  logic       glyph_enable;

  logic [7:0] plot_x;
  logic [7:0] plot_y;
  logic [5:0] plot_colour;
  logic       plot;

  logic       busy;
  logic       done;

  // Drawer side.
  modport slave (
    input  start, base_x, base_y, str_len, clear_bg, bg_colour,
    input  char_code, glyph_colour, glyph_enable,
    output char_addr, glyph_code, glyph_x, glyph_y,
    output plot_x, plot_y, plot_colour, plot, busy, done
  );

  // Environment side: HUD logic, string buffer, glyph LUT bank, VGA adapter.
  modport master (
    output start, base_x, base_y, str_len, clear_bg, bg_colour,
    output char_code, glyph_colour, glyph_enable,
    input  char_addr, glyph_code, glyph_x, glyph_y,
    input  plot_x, plot_y, plot_colour, plot, busy, done
  );

endinterface

// File: rtl/char_string_drawer.sv
// Renders a string of glyphs into the frame buffer, one plot strobe per pixel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; request fields latched on accept
// FETCH   | string buffer address for the current character presented
// WAIT    | buffer data latched as glyph code, cell scan counters cleared
// SCAN    | one cell pixel per cycle, row-major; plot registered next edge
// FLUSH   | lets the final registered pixel reach the plot outputs
// DONE    | single-cycle done pulse, busy still high
module char_string_drawer
  import char_string_drawer_pkg::*;
(
  input  logic clk_i,
  input  logic resetn_i,
  char_string_drawer_if.slave bus
);

  localparam logic [7:0] COL_LAST = 8'(CELL_W - 1);
  localparam logic [7:0] ROW_LAST = 8'(CELL_H - 1);
  localparam logic [7:0] X_STEP   = 8'(ADVANCE);
  localparam logic [9:0] X_LIMIT  = 10'(SCREEN_W);
  localparam logic [9:0] Y_LIMIT  = 10'(SCREEN_H);

  state_e     state_q;
  logic [3:0] idx_q;
  logic [4:0] len_q;
  logic [7:0] xoff_q;
  logic [7:0] base_x_q;
  logic [7:0] base_y_q;
  logic       clear_bg_q;
  logic [5:0] bg_colour_q;
  logic [3:0] char_addr_q;
  logic [5:0] glyph_code_q;
  logic [7:0] col_q;
  logic [7:0] row_q;
  logic       plot_q;
  logic [7:0] plot_x_q;
  logic [7:0] plot_y_q;
  logic [5:0] plot_colour_q;
  logic       busy_q;
  logic       done_q;

  logic [4:0] len_d;
  logic [9:0] ax_d;
  logic [9:0] ay_d;
  logic       plot_d;
  logic [5:0] plot_colour_d;
  logic       last_char_d;

  // Absolute pixel position and plot decision for the pixel currently on the glyph port.
  always_comb begin
    len_d         = sat_len(bus.str_len);
    // Wide sums so off-screen positions clip rather than wrap back onto the screen.
    ax_d          = {2'b00, base_x_q} + {2'b00, xoff_q} + {2'b00, col_q};
    ay_d          = {2'b00, base_y_q} + {2'b00, row_q};
    plot_d        = (bus.glyph_enable | clear_bg_q) & (ax_d < X_LIMIT) & (ay_d < Y_LIMIT);
    plot_colour_d = bus.glyph_enable ? bus.glyph_colour : bg_colour_q;
    last_char_d   = (({1'b0, idx_q} + 5'd1) == len_q);
  end

  // Sequencer with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      xoff_q        <= '0;
      base_x_q      <= '0;
      base_y_q      <= '0;
      clear_bg_q    <= 1'b0;
      bg_colour_q   <= '0;
      char_addr_q   <= '0;
      glyph_code_q  <= '0;
      col_q         <= '0;
      row_q         <= '0;
      plot_q        <= 1'b0;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_colour_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            base_x_q    <= bus.base_x;
            base_y_q    <= bus.base_y;
            len_q       <= len_d;
            clear_bg_q  <= bus.clear_bg;
            bg_colour_q <= bus.bg_colour;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            xoff_q      <= '0;
            if (len_d == 5'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              char_addr_q <= '0;
              state_q     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          glyph_code_q <= bus.char_code;
          col_q        <= '0;
          row_q        <= '0;
          state_q      <= S_SCAN;
        end
        S_SCAN: begin
          plot_q        <= plot_d;
          plot_x_q      <= ax_d[7:0];
          plot_y_q      <= ay_d[7:0];
          plot_colour_q <= plot_colour_d;
          if (col_q == COL_LAST) begin
            col_q <= '0;
            if (row_q == ROW_LAST) begin
              row_q <= '0;
              if (last_char_d) begin
                state_q <= S_FLUSH;
              end else begin
                // Next character: address is presented on entry to FETCH so the
                // buffer data is ready by the end of WAIT.
                idx_q       <= idx_q + 4'd1;
                char_addr_q <= idx_q + 4'd1;
                xoff_q      <= xoff_q + X_STEP;
                state_q     <= S_FETCH;
              end
            end else begin
              row_q <= row_q + 8'd1;
            end
          end else begin
            col_q <= col_q + 8'd1;
          end
        end
        S_FLUSH: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.char_addr   = char_addr_q;
  assign bus.glyph_code  = glyph_code_q;
  assign bus.glyph_x     = col_q;
  assign bus.glyph_y     = row_q;
  assign bus.plot        = plot_q;
  assign bus.plot_x      = plot_x_q;
  assign bus.plot_y      = plot_y_q;
  assign bus.plot_colour = plot_colour_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_char_string_drawer.sv
// Directed and randomized bench for char_string_drawer against a pixel-list model.
module tb_char_string_drawer;
  import char_string_drawer_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  char_string_drawer_if bus();

  char_string_drawer dut (
    .clk_i   (clk),
    .resetn_i(resetn),
    .bus     (bus)
  );

  logic [5:0] strbuf [16];

  // String buffer: synchronous read, data one cycle after the address.
  always @(posedge clk) bus.char_code <= strbuf[bus.char_addr];

  // Glyph LUT stand-in: a hand-drawn Y, a pseudo-random pattern for other codes.
  function automatic logic [6:0] glyph(input logic [5:0] code, input int x, input int y);
    logic       en;
    logic [5:0] col;
    if (code == CHAR_Y) begin
      en  = (y < 2) ? (x == 2 || x == 7) : (x == 4 || x == 5);
      col = 6'h3F;
    end else begin
      en  = (((x * 3) + (y * 5) + int'(code)) % 7) < 3;
      col = 6'((int'(code) + x + y) & 63);
    end
    return {en, col};
  endfunction

  always_comb {bus.glyph_enable, bus.glyph_colour} =
      glyph(bus.glyph_code, int'(bus.glyph_x), int'(bus.glyph_y));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  logic [21:0] exp_q[$];
  logic [21:0] act_q[$];
  int done_cyc;
  int busy_cnt;
  int max_addr;

  // Expected plot stream: every cell pixel in scan order, kept if visible.
  task automatic build_exp(input logic [7:0] bx, input logic [7:0] by, input int len,
                           input logic clr, input logic [5:0] bg);
    int ax;
    int ay;
    logic [6:0] g;
    exp_q.delete();
    for (int i = 0; i < len; i++)
      for (int r = 0; r < int'(CELL_H); r++)
        for (int c = 0; c < int'(CELL_W); c++) begin
          ax = int'(bx) + i * int'(ADVANCE) + c;
          ay = int'(by) + r;
          g  = glyph(strbuf[i], c, r);
          if ((g[6] || clr) && ax < int'(SCREEN_W) && ay < int'(SCREEN_H))
            exp_q.push_back({8'(ax), 8'(ay), g[6] ? g[5:0] : bg});
        end
  endtask

  // Issues one request; start cycle is cycle 1. Optionally re-pulses start at cycle poke.
  task automatic run_job(input logic [7:0] bx, input logic [7:0] by, input logic [4:0] len,
                         input logic clr, input logic [5:0] bg, input int poke);
    int n;
    act_q.delete();
    busy_cnt = 0;
    max_addr = 0;
    done_cyc = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_x = bx;
    bus.base_y = by;
    bus.str_len = len;
    bus.clear_bg = clr;
    bus.bg_colour = bg;
    n = 1;
    while (n < 2500) begin
      @(negedge clk);
      n++;
      bus.start = (poke > 0 && n == poke);
      if (bus.start) begin
        bus.base_x = ~bx;
        bus.str_len = 5'd1;
      end
      if (bus.busy) busy_cnt++;
      if (bus.busy && int'(bus.char_addr) > max_addr) max_addr = int'(bus.char_addr);
      if (bus.plot) act_q.push_back({bus.plot_x, bus.plot_y, bus.plot_colour});
      if (bus.done) begin
        done_cyc = n;
        break;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", int'(bus.done), 0);
    check("busy_after_done", int'(bus.busy), 0);
  endtask

  task automatic compare_job(input string tag, input int len);
    int first_bad;
    int exp_done;
    exp_done = (len == 0) ? 2 : len * (2 + int'(CELL_W * CELL_H)) + 3;
    check({tag, "_plot_count"}, act_q.size(), exp_q.size());
    first_bad = -1;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (first_bad < 0 && act_q[i] !== exp_q[i]) first_bad = i;
    check({tag, "_first_bad_plot_idx"}, first_bad, -1);
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_busy_cycles"}, busy_cnt, exp_done - 1);
    if (len > 0) check({tag, "_max_char_addr"}, max_addr, len - 1);
  endtask

  initial begin
    int cnt;
    int maxx;
    logic [7:0] rbx;
    logic [7:0] rby;
    logic [4:0] rlen;
    logic       rclr;
    logic [5:0] rbg;

    bus.start = 1'b0;
    bus.base_x = '0;
    bus.base_y = '0;
    bus.str_len = '0;
    bus.clear_bg = 1'b0;
    bus.bg_colour = '0;
    for (int i = 0; i < 16; i++) strbuf[i] = CHAR_Y;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_plot", int'(bus.plot), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_char_addr", int'(bus.char_addr), 0);
    check("rst_glyph_xy", int'({bus.glyph_x, bus.glyph_y}), 0);
    check("rst_plot_xyc", int'({bus.plot_x, bus.plot_y, bus.plot_colour}), 0);
    resetn = 1'b1;

    // Single Y at (10,20).
    build_exp(8'd10, 8'd20, 1, 1'b0, 6'h00);
    run_job(8'd10, 8'd20, 5'd1, 1'b0, 6'h00, 0);
    compare_job("single", 1);
    check("single_first_plot", int'(act_q.size() > 0 ? act_q[0] : 22'h0),
          int'({8'd12, 8'd20, 6'h3F}));
    check("single_count20", act_q.size(), 20);

    // Two Ys at the origin.
    build_exp(8'd0, 8'd0, 2, 1'b0, 6'h00);
    run_job(8'd0, 8'd0, 5'd2, 1'b0, 6'h00, 0);
    compare_job("two", 2);
    check("two_second_char_x", int'(act_q.size() > 20 ? act_q[20][21:14] : 8'h0), 14);

    // Right-edge clipping.
    build_exp(8'd155, 8'd30, 1, 1'b0, 6'h00);
    run_job(8'd155, 8'd30, 5'd1, 1'b0, 6'h00, 0);
    compare_job("clip", 1);
    maxx = 0;
    foreach (act_q[i]) if (int'(act_q[i][21:14]) > maxx) maxx = int'(act_q[i][21:14]);
    check("clip_max_x_lt_160", int'(maxx < 160), 1);
    check("clip_count", act_q.size(), 10);

    // Background fill.
    build_exp(8'd30, 8'd40, 1, 1'b1, 6'h05);
    run_job(8'd30, 8'd40, 5'd1, 1'b1, 6'h05, 0);
    compare_job("bg", 1);
    cnt = 0;
    foreach (act_q[i]) if (act_q[i][5:0] == 6'h05) cnt++;
    check("bg_count100", act_q.size(), 100);
    check("bg_colour_pixels", cnt, 80);

    // Empty string.
    build_exp(8'd5, 8'd5, 0, 1'b1, 6'h01);
    run_job(8'd5, 8'd5, 5'd0, 1'b1, 6'h01, 0);
    compare_job("len0", 0);

    // Start while busy is ignored.
    for (int i = 0; i < 16; i++) strbuf[i] = 6'($urandom_range(0, 63));
    build_exp(8'd20, 8'd60, 3, 1'b0, 6'h00);
    run_job(8'd20, 8'd60, 5'd3, 1'b0, 6'h00, 40);
    compare_job("busy_start", 3);

    // Reset in the middle of the first character's scan.
    for (int i = 0; i < 16; i++) strbuf[i] = CHAR_Y;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_x = 8'd0;
    bus.base_y = 8'd0;
    bus.str_len = 5'd2;
    bus.clear_bg = 1'b1;
    repeat (49) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_plot", int'(bus.plot), 0);
    check("midrst_busy", int'(bus.busy), 0);
    resetn = 1'b1;
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done || bus.plot) cnt++;
    end
    check("midrst_no_activity", cnt, 0);
    build_exp(8'd40, 8'd50, 1, 1'b0, 6'h00);
    run_job(8'd40, 8'd50, 5'd1, 1'b0, 6'h00, 0);
    compare_job("after_rst", 1);

    // Oversized length saturates.
    for (int i = 0; i < 16; i++) strbuf[i] = 6'($urandom_range(0, 63));
    build_exp(8'd0, 8'd100, int'(MAX_LEN), 1'b0, 6'h00);
    run_job(8'd0, 8'd100, 5'd20, 1'b0, 6'h00, 0);
    compare_job("sat", int'(MAX_LEN));

    // Randomized requests.
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 16; i++) strbuf[i] = 6'($urandom_range(0, 63));
      rbx  = 8'($urandom_range(0, 255));
      rby  = 8'($urandom_range(0, 125));
      rlen = 5'($urandom_range(0, 18));
      rclr = 1'($urandom_range(0, 1));
      rbg  = 6'($urandom_range(0, 63));
      build_exp(rbx, rby, (int'(rlen) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(rlen), rclr, rbg);
      run_job(rbx, rby, rlen, rclr, rbg, 0);
      compare_job("rand", (int'(rlen) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(rlen));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
